// File: rtl/effect_param_scheduler.sv
// effect_param_scheduler: debounced key/switch front panel driving per-effect divisors and frequencies.
// Define FX_PARAM_WRAP_EN to wrap divisors at the limits instead of saturating.
module effect_param_scheduler #(
   parameter int NUM_FX          = 4,
   parameter int CLK_HZ          = 50000000,
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int DIV_STEP        = 256,
   parameter int DIV_MIN         = 256,
   parameter int DIV_MAX         = 5120,
   parameter int DIV_RESET       = 2560
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   key3,
   input  logic                   key2,
   input  logic [9:0]             SW,
   output logic [NUM_FX-1:0]      fx_disabled,
   output logic [32*NUM_FX-1:0]   fx_frequency,
   output logic                   busy,
   output logic                   upd_valid,
   output logic [1:0]             upd_index
);
   localparam logic [31:0] F_RESET = 32'(CLK_HZ / DIV_RESET);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, DIVIDE, COMMIT} state_t;
   state_t state, state_nx;

   logic [1:0]        key_s1, key_s2, key_db, key_prev, press;
   logic [CW-1:0]     db_cnt [2];
   logic [NUM_FX-1:0] dis_s1;
   logic [31:0]       div_r [NUM_FX];
   logic [31:0]       div_l, quo, rem, cur_div, new_div;
   logic [32:0]       rem_sh, rem_diff;
   logic [1:0]        sel_l;
   logic [4:0]        bit_cnt;
   logic              sel_ok, sat, sat3, sat2, accept, ge;
   logic              unused_sw;

   // index 1 is key3, index 0 is key2; a press is the debounced falling edge
   assign press = key_prev & ~key_db;

   always_ff @(posedge CLK or posedge RST)
      if (RST) begin
         key_s1   <= '1;
         key_s2   <= '1;
         key_db   <= '1;
         key_prev <= '1;
         db_cnt[0] <= '0;
         db_cnt[1] <= '0;
      end else begin
         key_s1   <= {key3, key2};
         key_s2   <= key_s1;
         key_prev <= key_db;
         for (int k = 0; k < 2; k++)
            if (key_s2[k] == key_db[k]) db_cnt[k] <= '0;
            else if (db_cnt[k] == CW'(DEBOUNCE_CYCLES - 1)) begin
               key_db[k] <= key_s2[k];
               db_cnt[k] <= '0;
            end else db_cnt[k] <= db_cnt[k] + 1'b1;
      end

   always_ff @(posedge CLK or posedge RST)
      if (RST) begin
         dis_s1      <= '1;
         fx_disabled <= '1;
      end else begin
         dis_s1      <= ~SW[4 +: NUM_FX];
         fx_disabled <= dis_s1;
      end

   assign sel_ok  = {30'd0, SW[1:0]} < 32'(NUM_FX);
   assign cur_div = sel_ok ? div_r[SW[1:0]] : 32'(DIV_RESET);
   assign sat3    = cur_div < 32'(DIV_MIN + DIV_STEP);
   assign sat2    = cur_div > 32'(DIV_MAX - DIV_STEP);
`ifdef FX_PARAM_WRAP_EN
   assign new_div = press[1] ? (sat3 ? 32'(DIV_MAX) : cur_div - 32'(DIV_STEP))
                             : (sat2 ? 32'(DIV_MIN) : cur_div + 32'(DIV_STEP));
   assign sat     = 1'b0;
`else
   assign new_div = press[1] ? cur_div - 32'(DIV_STEP) : cur_div + 32'(DIV_STEP);
   assign sat     = press[1] ? sat3 : sat2;
`endif
   assign accept  = (state == IDLE) && SW[9] && sel_ok && (^press) && !sat;

   // restoring division step: shift in next dividend bit, subtract if it fits
   assign rem_sh   = {rem, quo[31]};
   assign rem_diff = rem_sh - {1'b0, div_l};
   assign ge       = rem_sh >= {1'b0, div_l};
   assign busy     = state != IDLE;
   assign unused_sw = ^{SW, rem_diff[32]};

   always_ff @(posedge CLK or posedge RST)
      if (RST) state <= IDLE;
      else state <= state_nx;

   always_comb begin
      state_nx = state;
      state_nx = (state == IDLE)   ? (accept ? DIVIDE : IDLE) :
                 (state == DIVIDE) ? ((bit_cnt == 5'd31) ? COMMIT : DIVIDE) : IDLE;
   end

   always_ff @(posedge CLK or posedge RST)
      if (RST) begin
         for (int i = 0; i < NUM_FX; i++) div_r[i] <= 32'(DIV_RESET);
         fx_frequency <= {NUM_FX{F_RESET}};
         upd_valid    <= 1'b0;
         upd_index    <= '0;
         sel_l        <= '0;
         div_l        <= 32'(DIV_RESET);
         quo          <= '0;
         rem          <= '0;
         bit_cnt      <= '0;
      end else begin
         upd_valid <= 1'b0;
         if (accept) begin
            div_r[SW[1:0]] <= new_div;
            div_l          <= new_div;
            sel_l          <= SW[1:0];
            quo            <= 32'(CLK_HZ);
            rem            <= '0;
            bit_cnt        <= '0;
         end else if (state == DIVIDE) begin
            quo     <= {quo[30:0], ge};
            rem     <= ge ? rem_diff[31:0] : rem_sh[31:0];
            bit_cnt <= bit_cnt + 1'b1;
         end else if (state == COMMIT) begin
            fx_frequency[{sel_l, 5'd0} +: 32] <= quo;
            upd_valid <= 1'b1;
            upd_index <= sel_l;
         end
      end
endmodule

// File: tb/tb_effect_param_scheduler.sv
// tb_effect_param_scheduler: directed stimulus with a scoreboard of expected frequency updates.
module tb_effect_param_scheduler;
   logic         CLK = 0, RST = 0, key3 = 1, key2 = 1;
   logic [9:0]   SW = '0;
   logic [3:0]   fx_disabled;
   logic [127:0] fx_frequency;
   logic         busy, upd_valid;
   logic [1:0]   upd_index;

   int checks = 0, errors = 0, upd_count = 0, busy_run = 0, mon_idx, n, upd0;
   int mdiv [4];
   logic [33:0] sb [$];
   logic [33:0] e;

   effect_param_scheduler #(.DEBOUNCE_CYCLES(4)) dut (
      .CLK(CLK), .RST(RST), .key3(key3), .key2(key2), .SW(SW),
      .fx_disabled(fx_disabled), .fx_frequency(fx_frequency),
      .busy(busy), .upd_valid(upd_valid), .upd_index(upd_index)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // each update is popped and checked against the scoreboard, including its latency
   always @(negedge CLK) begin
      if (RST) busy_run = 0;
      else if (busy) busy_run++;
      else begin
         if (upd_valid) begin
            upd_count++;
            chk("upd_expected", 32'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
               e = sb.pop_front();
               mon_idx = int'(e[33:32]);
               chk("upd_index", 32'(upd_index), 32'(e[33:32]));
               chk("upd_freq", fx_frequency[mon_idx*32 +: 32], e[31:0]);
               chk("busy_cycles", busy_run, 33);
            end
         end
         busy_run = 0;
      end
   end

   task automatic cyc(input int k);
      repeat (k) @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      RST = 1;
      for (int i = 0; i < 4; i++) mdiv[i] = 2560;
      sb.delete();
      cyc(2);
      RST = 0;
      cyc(1);
   endtask

   task automatic model(input bit k3, input bit k2);
      int s, d, nd;
      if (!SW[9] || !(k3 ^ k2)) return;
      s = int'(SW[1:0]);
      d = mdiv[s];
      if (k3) begin
         if (d - 256 < 256) begin
`ifdef FX_PARAM_WRAP_EN
            nd = 5120;
`else
            return;
`endif
         end else nd = d - 256;
      end else begin
         if (d + 256 > 5120) begin
`ifdef FX_PARAM_WRAP_EN
            nd = 256;
`else
            return;
`endif
         end else nd = d + 256;
      end
      mdiv[s] = nd;
      sb.push_back({2'(s), 32'(50000000 / nd)});
   endtask

   task automatic raw_keys(input bit k3, input bit k2, input int hold);
      key3 = ~k3;
      key2 = ~k2;
      cyc(hold);
      key3 = 1;
      key2 = 1;
      cyc(10);
   endtask

   task automatic press(input bit k3, input bit k2);
      model(k3, k2);
      raw_keys(k3, k2, 8);
      cyc(45);
   endtask

   task automatic check_all();
      for (int i = 0; i < 4; i++)
         chk($sformatf("slice%0d", i), fx_frequency[i*32 +: 32], 32'(50000000 / mdiv[i]));
   endtask

   task automatic wait_busy();
      n = 0;
      while (!busy && n < 30) begin
         cyc(1);
         n++;
      end
      chk("busy_seen", 32'(busy), 1);
   endtask

   initial begin
      #1 do_reset();
      check_all();
      chk("reset_disabled", 32'(fx_disabled), 32'hF);
      chk("reset_busy", 32'(busy), 0);
      chk("reset_upd", 32'(upd_valid), 0);
      chk("reset_freq", fx_frequency[31:0], 19531);

      SW = 10'b10_0001_0000;
      cyc(3);
      chk("disabled_sw4", 32'(fx_disabled), 32'hE);
      press(1, 0);
      chk("dec_slice0", fx_frequency[31:0], 21701);

      SW[1:0] = 2'd2;
      press(0, 1);
      chk("inc_slice2", fx_frequency[95:64], 17755);
      check_all();

      SW = 10'b10_1010_0001;
      cyc(3);
      chk("disabled_mix", 32'(fx_disabled), 32'h5);
      for (int i = 0; i < 9; i++) press(1, 0);
      chk("sat_lo_reach", fx_frequency[63:32], 195312);
      upd0 = upd_count;
      press(1, 0);
`ifdef FX_PARAM_WRAP_EN
      chk("wrap_lo", fx_frequency[63:32], 9765);
      chk("wrap_lo_upd", upd_count - upd0, 1);
`else
      chk("sat_lo_hold", fx_frequency[63:32], 195312);
      chk("sat_lo_upd", upd_count - upd0, 0);
`endif
      check_all();

      do_reset();
      for (int i = 0; i < 10; i++) press(0, 1);
      chk("sat_hi_reach", fx_frequency[63:32], 9765);
      upd0 = upd_count;
      press(0, 1);
`ifndef FX_PARAM_WRAP_EN
      chk("sat_hi_upd", upd_count - upd0, 0);
`endif
      check_all();

      upd0 = upd_count;
      raw_keys(1, 0, 3);
      cyc(45);
      chk("glitch_upd", upd_count - upd0, 0);
      SW[9] = 0;
      press(1, 0);
      chk("edit_off_upd", upd_count - upd0, 0);
      SW[9] = 1;
      press(1, 1);
      chk("both_keys_upd", upd_count - upd0, 0);
      check_all();

      SW[1:0] = 2'd0;
      upd0 = upd_count;
      model(1, 0);
      key3 = 0;
      wait_busy();
      key3 = 1;
      key2 = 0;
      cyc(8);
      key2 = 1;
      cyc(50);
      chk("busy_drop_upd", upd_count - upd0, 1);
      check_all();

      SW[1:0] = 2'd3;
      key3 = 0;
      wait_busy();
      cyc(9);
      key3 = 1;
      upd0 = upd_count;
      do_reset();
      cyc(50);
      chk("abort_upd", upd_count - upd0, 0);
      chk("abort_busy", 32'(busy), 0);
      chk("abort_slice3", fx_frequency[127:96], 19531);
      check_all();

      chk("sb_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
